// File: rtl/serial_adder.sv
// Bit-serial a+b+cin: one full-adder cell, registered carry, one bit per clock.
// Latency: start accepted at edge E0 -> done strobe and sum/cout updated at E0+WIDTH.
// No backpressure: start is taken only in IDLE and is dropped while busy.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_n;

    // Single full-adder cell operating on the LSBs of the operand shifters.
    always_comb begin
        fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last_bit = (cnt == CW'(WIDTH - 1));
        // Concatenate-then-drop keeps the shift legal for WIDTH == 1.
        res_cat  = {fa_s, res_sh};
        res_n    = res_cat[WIDTH:1];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = BUSY;
            BUSY:    if (last_bit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_n;
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= res_n;
                        cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a WIDTH=8 instance and a WIDTH=1 instance on one clock.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       busy1, done1, cout1, sum1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic [8:0] exp);
        int lat;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_at_e0", busy8, 1);
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_latency", lat, 8);
        chk("result", {cout8, sum8}, exp);
        @(posedge clk); #1;
        chk("done_cleared", done8, 0);
        chk("busy_cleared", busy8, 0);
    endtask

    logic [1:0] exp1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    int         done_at [$];
    logic       prev_done;

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_w8", {busy8, done8, cout8, sum8}, 0);
        chk("rst_w1", {busy1, done1, cout1, sum1}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic vectors
        op8(8'h00, 8'h00, 1'b0, 9'h000);
        op8(8'hFF, 8'h01, 1'b0, 9'h100);
        op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        op8(8'h5A, 8'h3C, 1'b1, 9'h097);

        // start during BUSY is ignored; outputs hold the old result until completion
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("hold_e7_result", {cout8, sum8}, 9'h097);
        chk("hold_e7_done", done8, 0);
        @(posedge clk); #1;
        chk("ign_e8_done", done8, 1);
        chk("ign_e8_result", {cout8, sum8}, 9'h030);
        @(posedge clk); #1;
        chk("ign_e9_busy", busy8, 0);
        @(posedge clk); #1;
        chk("ign_no_requeue", busy8, 0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", {busy8, done8, cout8, sum8}, 0);
        @(negedge clk);
        rst = 1'b0;
        op8(8'h01, 8'h01, 1'b1, 9'h003);

        // start held high: done every 10 cycles, never back-to-back
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        prev_done = done8;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done8) done_at.push_back(k);
            chk("no_double_done", done8 & prev_done, 0);
            prev_done = done8;
        end
        start8 = 1'b0;
        chk("held_done_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("held_done_0", done_at[0], 8);
            chk("held_done_1", done_at[1], 18);
            chk("held_done_2", done_at[2], 28);
        end
        chk("held_result", {cout8, sum8}, 9'h007);
        repeat (12) begin @(posedge clk); #1; end
        chk("held_drained", busy8, 0);

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            @(posedge clk); #1;
            chk("w1_done", done1, 1);
            chk("w1_result", {cout1, sum1}, exp1[i]);
            @(posedge clk); #1;
            chk("w1_done_clr", done1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that computes a + b + cin one bit per clock. It uses a single full-adder cell and a registered carry.
- It is the sequential stage that consumes the combinational full-adder cell. It serves area-constrained datapaths where a WIDTH-bit ripple adder is too large.
- The operands are captured on a start pulse. The result is presented with a one-cycle done strobe after WIDTH processing cycles.
- Its {cout, sum} result must match the parallel full-adder contract exactly.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request strobe; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepted start.
- b  input  WIDTH  operand B; sampled on the accepted start.
- cin  input  1  carry-in; sampled on the accepted start.
- busy  output  1  high while an operation is in progress (BUSY or DONE).
- done  output  1  one-cycle strobe; marks sum/cout as updated.
- sum  output  WIDTH  result bits [WIDTH-1:0] of a+b+cin.
- cout  output  1  result bit WIDTH (carry-out).

Behaviour:
- Reset: asynchronous assertion sets all of the following at once, with no clock needed:
  - state = IDLE
  - busy = 0, done = 0, sum = 0, cout = 0
  - internal shift registers, carry register and bit counter = 0
- Release: first active edge after rst deasserts is a normal IDLE cycle.
- FSM states: IDLE, BUSY, DONE. All outputs are registered; none are combinational from inputs.
- IDLE:
  - busy = 0.
  - If start = 1 at an edge: load a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0, and go to BUSY.
- BUSY, every edge:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by one.
  - res_sh shifts right by one, with s entering at the MSB.
  - cnt increments.
  - On the edge where cnt == WIDTH-1, the final bit is processed. At that edge also:
    - sum <= the completed res_sh, including the last s;
    - cout <= the final carry-out;
    - done <= 1;
    - go to DONE.
  - BUSY therefore lasts exactly WIDTH cycles.
- DONE:
  - done = 1 for exactly one cycle, then the next edge clears done and returns to IDLE.
- Latency: start accepted at edge E0 gives done high from edge E0+WIDTH for one cycle. Sum/cout are valid from that same edge.
- Throughput: a new start is accepted no earlier than edge E0+WIDTH+1, giving one result per WIDTH+2 cycles when start is held high.
- Output hold:
  - sum and cout change only on the completion edge or on reset.
  - They hold the last result through the following IDLE and the next BUSY.
- start handling:
  - Ignored in BUSY and DONE; no queuing, and operand changes there have no effect.
  - start held continuously re-triggers on the first IDLE cycle.
- Arithmetic: {cout, sum} == a + b + cin, computed at WIDTH+1 bits with no truncation. Maximum case: (2^WIDTH-1)*2+1 = 2^(WIDTH+1)-1.
- WIDTH = 1: BUSY lasts one cycle; done is at E0+1.
- Reset mid-operation: the operation is aborted with no partial result. All outputs go to their reset values, including the previous sum and cout.
- Counter width: $clog2(WIDTH)+1 bits, enough to hold WIDTH-1 without wrap.

Test Plan:
- WIDTH=8: rst pulse, then start with a=8'h00, b=8'h00, cin=0 at E0.
  - busy=1 from E0; done=1 only at E0+8; sum=8'h00, cout=0; busy=0 at E0+9.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 gives sum=8'h00, cout=1.
  - Then a=8'hFF, b=8'hFF, cin=1 gives sum=8'hFF, cout=1.
  - Then a=8'h5A, b=8'h3C, cin=1 gives sum=8'h97, cout=0.
- WIDTH=8: start a=8'h10, b=8'h20, cin=0, then pulse start during BUSY with a=8'hFF, b=8'hFF.
  - Second request is ignored; the result is sum=8'h30, cout=0.
  - sum/cout keep their previous values until E0+8.
- WIDTH=8: assert rst asynchronously mid-cycle at E0+4.
  - busy, done, sum and cout go to 0 before the next edge.
  - After release, a=8'h01, b=8'h01, cin=1 completes with sum=8'h03, cout=0.
- WIDTH=8: hold start=1 continuously with constant operands.
  - done pulses at E0+8, E0+18, E0+28 (period 10); never two consecutive done cycles.
- WIDTH=1: exhaustive 8 combinations of a, b, cin.
  - done one edge after acceptance each time; {cout, sum} == a+b+cin for all eight.
